sdm_sync_outp_buf: RTL and testbench
====================================

Name: sdm_sync_outp_buf

Overview:
- Synchronous successor to the asynchronous 1-of-4 output buffer. Generalised to CN independent SDM virtual circuits.
- Each virtual circuit has its own PD-deep flit FIFO with valid/ready handshakes on both sides and a per-circuit eof (end-of-frame) tail marker.
- Optional packet mode holds a circuit's output until a whole frame is buffered.
- Sits between the router crossbar outputs and the inter-router link of the synchronous SDM router.

Parameters:
- DW, 16, data width of one virtual circuit (bits per flit).
- PD, 4, FIFO depth per virtual circuit in flits; any integer >= 2.
- CN, 2, number of SDM virtual circuits (independent channels).
- PKT_MODE, 0, 0 = cut-through; 1 = frame store-and-forward, with full-FIFO release.
- CW, $clog2(PD+1), occupancy counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- i_data  input  CN*DW  input flits; circuit c occupies bits [c*DW +: DW]
- i_eof  input  CN  tail-flit marker per circuit
- i_vld  input  CN  input valid per circuit
- i_rdy  output  CN  input ready per circuit
- o_data  output  CN*DW  output flits, same packing as i_data
- o_eof  output  CN  output tail marker
- o_vld  output  CN  output valid per circuit
- o_rdy  input  CN  downstream ready per circuit
- fill  output  CN*CW  occupancy per circuit; circuit c occupies bits [c*CW +: CW]

Behaviour:
- One clock; reset is asynchronous and active-high. On rst=1:
  - wr/rd pointers, count and eof_cnt of every circuit = 0
  - i_rdy = 0, o_vld = 0, fill = 0, o_eof = 0
  - o_data content is don't-care.
- i_rdy becomes 1 in the first cycle after rst deasserts.
- Circuits are fully independent. No shared state, no arbitration. A stall on one circuit never affects another.
- Per circuit c:
  - Push when i_vld[c] & i_rdy[c] at a rising edge: store {i_eof, i_data} at wr_ptr, wr_ptr++.
  - Pop when o_vld[c] & o_rdy[c] at a rising edge: rd_ptr++.
- i_rdy[c] = (count < PD) & ~rst. It is combinational from registered count. It does not depend on o_rdy (no full-bypass).
- First-word fall-through: o_data/o_eof are read combinationally from the entry at rd_ptr.
- Latency: a flit pushed at edge n is presented at o_vld in the cycle following edge n. There is no same-cycle empty bypass.
- o_vld[c]:
  - PKT_MODE=0: o_vld = (count > 0).
  - PKT_MODE=1: o_vld = (count > 0) & ((eof_cnt > 0) | (count == PD)). The full-FIFO release prevents deadlock for frames longer than PD.
- eof_cnt[c] counts tail flits held in the FIFO:
  - +1 on push with i_eof=1; -1 on pop with o_eof=1.
  - Both in the same cycle: unchanged.
  - Width CW.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. fill[c] = count.
- Pointer wrap: pointers run 0..PD-1 and wrap to 0 after PD-1. PD is not required to be a power of two.
- Simultaneous push and pop:
  - Allowed whenever count is 1..PD-1.
  - At count==0 only a push can occur (o_vld=0).
  - At count==PD only a pop can occur (i_rdy=0); count becomes PD-1 and i_rdy rises the next cycle.
- Output stability: while o_vld[c]=1 and o_rdy[c]=0, o_data/o_eof of c hold constant. o_vld never drops without a pop.
- PKT_MODE=1 exception: o_vld may rise mid-frame only by reaching count==PD. Once raised, it stays up until at least one pop.
- Reset mid-operation: all buffered flits are discarded immediately (asynchronous). No partial-frame recovery; an upstream frame in flight is lost.
- No overflow/underflow states are reachable. An i_vld with i_rdy=0 is ignored and must be held by upstream.

Test Plan:
- Reset/idle: assert rst mid-run with 3 flits in circuit 0 -> o_vld=00, fill=0, i_rdy=00 during reset; i_rdy=11 the cycle after release.
- Fill/drain, PD=4, CN=2, o_rdy=0: push 0x1111..0x4444 on circuit 0 -> i_rdy[0]=0 after the 4th push, fill[0]=4; circuit 1 unaffected. Then o_rdy=1 -> outputs 0x1111,0x2222,0x3333,0x4444 in order.
- Wrap and concurrency: continuous push/pop with o_rdy=1 for 20 flits (0x0000..0x0013) -> fill stays 1, order preserved across pointer wrap, one cycle of latency.
- Backpressure stability: o_rdy[1] toggles randomly -> o_data[1] is held while stalled, no flit lost or duplicated; circuit 0 throughput is unaffected.
- Packet mode, PKT_MODE=1: push 3 flits with eof on the 3rd -> o_vld stays 0 until the eof flit is stored, then 3 pops with o_eof=1 on the last. A 6-flit frame into PD=4 -> o_vld rises at fill=4, and the frame completes without deadlock.
- Full boundary: at fill=PD, pop and attempted push in the same cycle -> the push is refused, fill=PD-1, i_rdy=1 the next cycle.

Source files
------------

// File: rtl/sdm_sync_outp_buf.sv
// sdm_sync_outp_buf
//   Per-circuit output buffer for the synchronous SDM router. Each of the CN
//   virtual circuits has an independent PD-deep first-word-fall-through FIFO.
//   Every entry holds one flit plus its end-of-frame marker. The circuits share
//   no state, so a stall on one circuit never affects another.
//
//   PKT_MODE=0 : cut-through. A circuit presents a flit as soon as it holds one.
//   PKT_MODE=1 : frame store-and-forward. A circuit presents flits only once a
//                tail flit is buffered, or once its FIFO is full. The full-FIFO
//                release keeps frames longer than PD from deadlocking.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   i_data  input flits, circuit c at [c*DW +: DW]
//   i_eof   tail-flit marker per circuit
//   i_vld   input valid per circuit
//   i_rdy   input ready per circuit (count < PD, low during reset)
//   o_data  output flits, same packing as i_data
//   o_eof   output tail marker per circuit
//   o_vld   output valid per circuit
//   o_rdy   downstream ready per circuit
//   fill    occupancy per circuit, circuit c at [c*CW +: CW]

module sdm_sync_outp_buf #(
  parameter int DW       = 16,
  parameter int PD       = 4,
  parameter int CN       = 2,
  parameter int PKT_MODE = 0,
  localparam int CW      = $clog2(PD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CN*DW-1:0] i_data,
  input  logic [CN-1:0]    i_eof,
  input  logic [CN-1:0]    i_vld,
  output logic [CN-1:0]    i_rdy,
  output logic [CN*DW-1:0] o_data,
  output logic [CN-1:0]    o_eof,
  output logic [CN-1:0]    o_vld,
  input  logic [CN-1:0]    o_rdy,
  output logic [CN*CW-1:0] fill
);

  localparam int PW = (PD > 1) ? $clog2(PD) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(PD - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(PD);

  for (genvar c = 0; c < CN; c++) begin : g_ch
    logic [DW:0]    mem [PD];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  eof_cnt;
    logic [DW:0]    head;
    logic           rdy;
    logic           vld;
    logic           push;
    logic           pop;
    logic           eof_in;
    logic           eof_out;

    // Ready comes only from the registered count; a pop in the same cycle
    // does not open a slot until the next cycle.
    assign rdy  = (count < CNT_FULL) & ~rst;
    assign head = mem[rd_ptr];

    if (PKT_MODE != 0) begin : g_pkt
      assign vld = (count != '0) & ((eof_cnt != '0) | (count == CNT_FULL));
    end else begin : g_cut
      assign vld = (count != '0);
    end

    assign push    = i_vld[c] & rdy;
    assign pop     = vld & o_rdy[c];
    assign eof_in  = push & i_eof[c];
    assign eof_out = pop & head[DW];

    // Flit storage carries no reset; an entry is only visible once counted.
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= {i_eof[c], i_data[c*DW +: DW]};
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        eof_cnt <= '0;
      end else begin
        if (push) begin
          wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        case ({eof_in, eof_out})
          2'b10:   eof_cnt <= eof_cnt + 1'b1;
          2'b01:   eof_cnt <= eof_cnt - 1'b1;
          default: eof_cnt <= eof_cnt;
        endcase
      end
    end

    assign i_rdy[c]              = rdy;
    assign o_vld[c]              = vld;
    assign o_data[c*DW +: DW]    = head[DW-1:0];
    // The marker is gated so that it reads 0 whenever nothing is presented.
    assign o_eof[c]              = head[DW] & vld;
    assign fill[c*CW +: CW]      = count;
  end

endmodule

// File: tb/tb_sdm_sync_outp_buf.sv
module tb_sdm_sync_outp_buf;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] i_data, o_data;
  logic [1:0]  i_eof, i_vld, i_rdy, o_eof, o_vld, o_rdy;
  logic [5:0]  fill;

  logic [31:0] p_i_data, p_o_data;
  logic [1:0]  p_i_eof, p_i_vld, p_i_rdy, p_o_eof, p_o_vld, p_o_rdy;
  logic [5:0]  p_fill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdm_sync_outp_buf #(.DW(16), .PD(4), .CN(2), .PKT_MODE(0)) u_dut (
    .clk(clk), .rst(rst),
    .i_data(i_data), .i_eof(i_eof), .i_vld(i_vld), .i_rdy(i_rdy),
    .o_data(o_data), .o_eof(o_eof), .o_vld(o_vld), .o_rdy(o_rdy),
    .fill(fill)
  );

  sdm_sync_outp_buf #(.DW(16), .PD(4), .CN(2), .PKT_MODE(1)) u_pkt (
    .clk(clk), .rst(rst),
    .i_data(p_i_data), .i_eof(p_i_eof), .i_vld(p_i_vld), .i_rdy(p_i_rdy),
    .o_data(p_o_data), .o_eof(p_o_eof), .o_vld(p_o_vld), .o_rdy(p_o_rdy),
    .fill(p_fill)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if (o_vld !== 2'b00 || fill !== 6'd0 || i_rdy !== 2'b00 || o_eof !== 2'b00) begin
      errors++;
      $display("FAIL reset_state o_vld=%b fill=%h i_rdy=%b o_eof=%b exp 00/00/00/00", o_vld, fill, i_rdy, o_eof);
    end
    checks++;
    if (p_i_rdy !== 2'b00 || p_o_vld !== 2'b00) begin
      errors++;
      $display("FAIL reset_state_pkt i_rdy=%b o_vld=%b exp 00/00", p_i_rdy, p_o_vld);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (i_rdy !== 2'b11 || p_i_rdy !== 2'b11) begin
      errors++;
      $display("FAIL reset_release i_rdy=%b p_i_rdy=%b exp 11", i_rdy, p_i_rdy);
    end
    tick();
  endtask

  task automatic fill_ch0_four;
    o_rdy = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      i_data[15:0] = 16'(k * 16'h1111);
      i_vld = 2'b01;
      tick();
      checks++;
      if (fill[2:0] !== 3'(k)) begin
        errors++;
        $display("FAIL fill_count k=%0d got %0d exp %0d", k, fill[2:0], k);
      end
    end
    i_vld = 2'b00;
  endtask

  task automatic test_fill_drain;
    fill_ch0_four();
    checks++;
    if (i_rdy !== 2'b10 || fill[5:3] !== 3'd0 || o_vld !== 2'b01) begin
      errors++;
      $display("FAIL full_state i_rdy=%b fill1=%0d o_vld=%b exp 10/0/01", i_rdy, fill[5:3], o_vld);
    end
    o_rdy = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (o_vld[0] !== 1'b1 || o_data[15:0] !== 16'(k * 16'h1111)) begin
        errors++;
        $display("FAIL drain_order k=%0d got vld=%b data=%h exp 1/%h", k, o_vld[0], o_data[15:0], 16'(k * 16'h1111));
      end
      tick();
    end
    checks++;
    if (o_vld !== 2'b00 || fill !== 6'd0) begin
      errors++;
      $display("FAIL drain_empty o_vld=%b fill=%h exp 00/00", o_vld, fill);
    end
    o_rdy = 2'b00;
  endtask

  task automatic test_full_boundary;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h2222; exp_d[1] = 16'h3333; exp_d[2] = 16'h4444;
    fill_ch0_four();
    i_data[15:0] = 16'h5555;
    i_vld = 2'b01;
    o_rdy = 2'b01;
    checks++;
    if (i_rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_rdy got %b exp 0", i_rdy[0]);
    end
    tick();
    i_vld = 2'b00;
    o_rdy = 2'b00;
    checks++;
    if (fill[2:0] !== 3'd3 || i_rdy[0] !== 1'b1 || o_data[15:0] !== 16'h2222) begin
      errors++;
      $display("FAIL full_pop_push fill=%0d i_rdy=%b data=%h exp 3/1/2222", fill[2:0], i_rdy[0], o_data[15:0]);
    end
    o_rdy = 2'b01;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_vld[0] !== 1'b1 || o_data[15:0] !== exp_d[k]) begin
        errors++;
        $display("FAIL full_drain k=%0d got vld=%b data=%h exp 1/%h", k, o_vld[0], o_data[15:0], exp_d[k]);
      end
      tick();
    end
    checks++;
    if (o_vld[0] !== 1'b0 || fill[2:0] !== 3'd0) begin
      errors++;
      $display("FAIL full_refused_flit o_vld=%b fill=%0d exp 0/0", o_vld[0], fill[2:0]);
    end
    o_rdy = 2'b00;
  endtask

  task automatic test_wrap;
    o_rdy = 2'b01;
    for (int k = 0; k < 20; k++) begin
      i_data[15:0] = 16'(k);
      i_vld = 2'b01;
      if (k == 0) begin
        checks++;
        if (o_vld[0] !== 1'b0) begin
          errors++;
          $display("FAIL wrap_no_bypass o_vld=%b exp 0", o_vld[0]);
        end
      end
      tick();
      checks++;
      if (fill[2:0] !== 3'd1 || o_vld[0] !== 1'b1 || o_data[15:0] !== 16'(k)) begin
        errors++;
        $display("FAIL wrap k=%0d fill=%0d vld=%b data=%h exp 1/1/%h", k, fill[2:0], o_vld[0], o_data[15:0], 16'(k));
      end
    end
    i_vld = 2'b00;
    tick();
    checks++;
    if (fill[2:0] !== 3'd0 || o_vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end fill=%0d vld=%b exp 0/0", fill[2:0], o_vld[0]);
    end
    o_rdy = 2'b00;
  endtask

  task automatic test_back_to_back;
    logic [23:0] pat;
    logic [15:0] q1 [$];
    logic [15:0] nxt1;
    logic [15:0] nxt0;
    pat  = 24'b1011_0010_0111_0001_0000_1101;
    nxt1 = 16'hA000;
    nxt0 = 16'hC000;
    for (int cyc = 0; cyc < 24; cyc++) begin
      o_rdy  = {pat[cyc], 1'b1};
      i_vld  = 2'b11;
      i_data = {nxt1, nxt0};
      if (o_vld[1]) begin
        checks++;
        if (q1.size() == 0 || o_data[31:16] !== q1[0]) begin
          errors++;
          $display("FAIL bp_ch1 cyc=%0d got %h exp %h", cyc, o_data[31:16], (q1.size() == 0) ? 16'hxxxx : q1[0]);
        end
        if (o_rdy[1] && q1.size() != 0) void'(q1.pop_front());
      end
      if (i_rdy[1]) begin
        q1.push_back(nxt1);
        nxt1 = nxt1 + 16'd1;
      end
      if (cyc > 0) begin
        checks++;
        if (o_vld[0] !== 1'b1 || o_data[15:0] !== nxt0 - 16'd1 || fill[2:0] !== 3'd1 || i_rdy[0] !== 1'b1) begin
          errors++;
          $display("FAIL bp_ch0 cyc=%0d vld=%b data=%h fill=%0d rdy=%b exp 1/%h/1/1", cyc, o_vld[0], o_data[15:0], fill[2:0], i_rdy[0], nxt0 - 16'd1);
        end
      end
      nxt0 = nxt0 + 16'd1;
      tick();
    end
    i_vld = 2'b00;
    o_rdy = 2'b11;
    for (int n = 0; n < 10 && q1.size() > 0; n++) begin
      checks++;
      if (o_vld[1] !== 1'b1 || o_data[31:16] !== q1[0]) begin
        errors++;
        $display("FAIL bp_drain n=%0d vld=%b got %h exp %h", n, o_vld[1], o_data[31:16], q1[0]);
      end
      void'(q1.pop_front());
      tick();
    end
    checks++;
    if (q1.size() != 0 || o_vld !== 2'b00 || fill !== 6'd0) begin
      errors++;
      $display("FAIL bp_end left=%0d o_vld=%b fill=%h exp 0/00/00", q1.size(), o_vld, fill);
    end
    o_rdy = 2'b00;
  endtask

  task automatic test_pkt_mode;
    int idx;
    int got;
    bit first_seen;
    p_o_rdy = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      p_i_data[15:0] = 16'(16'h0A00 + k);
      p_i_eof = {1'b0, k == 3};
      p_i_vld = 2'b01;
      checks++;
      if (p_o_vld[0] !== 1'b0) begin
        errors++;
        $display("FAIL pkt_hold k=%0d o_vld=%b exp 0", k, p_o_vld[0]);
      end
      tick();
    end
    p_i_vld = 2'b00;
    p_i_eof = 2'b00;
    checks++;
    if (p_o_vld[0] !== 1'b1 || p_fill[2:0] !== 3'd3) begin
      errors++;
      $display("FAIL pkt_release o_vld=%b fill=%0d exp 1/3", p_o_vld[0], p_fill[2:0]);
    end
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (p_o_vld[0] !== 1'b1 || p_o_data[15:0] !== 16'(16'h0A00 + k) || p_o_eof[0] !== (k == 3)) begin
        errors++;
        $display("FAIL pkt_pop k=%0d vld=%b data=%h eof=%b exp 1/%h/%b", k, p_o_vld[0], p_o_data[15:0], p_o_eof[0], 16'(16'h0A00 + k), k == 3);
      end
      tick();
    end
    checks++;
    if (p_o_vld[0] !== 1'b0 || p_fill[2:0] !== 3'd0) begin
      errors++;
      $display("FAIL pkt_empty o_vld=%b fill=%0d exp 0/0", p_o_vld[0], p_fill[2:0]);
    end

    idx = 1;
    got = 0;
    first_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      p_i_vld        = {1'b0, idx <= 6};
      p_i_data[15:0] = 16'(16'h0B00 + idx);
      p_i_eof        = {1'b0, idx == 6};
      if (p_o_vld[0]) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          checks++;
          if (p_fill[2:0] !== 3'd4) begin
            errors++;
            $display("FAIL long_first_rise fill=%0d exp 4", p_fill[2:0]);
          end
        end
        if (idx <= 6) begin
          checks++;
          if (p_fill[2:0] !== 3'd4) begin
            errors++;
            $display("FAIL long_midframe cyc=%0d fill=%0d exp 4", cyc, p_fill[2:0]);
          end
        end
        got++;
        checks++;
        if (p_o_data[15:0] !== 16'(16'h0B00 + got) || p_o_eof[0] !== (got == 6)) begin
          errors++;
          $display("FAIL long_order n=%0d data=%h eof=%b exp %h/%b", got, p_o_data[15:0], p_o_eof[0], 16'(16'h0B00 + got), got == 6);
        end
      end
      if (p_i_vld[0] && p_i_rdy[0]) idx++;
      tick();
    end
    p_i_vld = 2'b00;
    p_i_eof = 2'b00;
    checks++;
    if (got != 6 || p_o_vld[0] !== 1'b0 || p_fill[2:0] !== 3'd0) begin
      errors++;
      $display("FAIL long_complete got=%0d o_vld=%b fill=%0d exp 6/0/0", got, p_o_vld[0], p_fill[2:0]);
    end
    p_o_rdy = 2'b00;
  endtask

  task automatic test_reset_mid_run;
    o_rdy = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      i_data[15:0] = 16'(16'h0D00 + k);
      i_vld = 2'b01;
      tick();
    end
    i_vld = 2'b00;
    checks++;
    if (fill[2:0] !== 3'd3 || o_vld !== 2'b01) begin
      errors++;
      $display("FAIL mid_pre fill=%0d o_vld=%b exp 3/01", fill[2:0], o_vld);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_vld !== 2'b00 || fill !== 6'd0 || i_rdy !== 2'b00 || o_eof !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset o_vld=%b fill=%h i_rdy=%b o_eof=%b exp 00/00/00/00", o_vld, fill, i_rdy, o_eof);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (i_rdy !== 2'b11 || fill !== 6'd0 || o_vld !== 2'b00) begin
      errors++;
      $display("FAIL mid_release i_rdy=%b fill=%h o_vld=%b exp 11/00/00", i_rdy, fill, o_vld);
    end
  endtask

  initial begin
    rst      = 1'b1;
    i_data   = '0; i_eof   = '0; i_vld   = '0; o_rdy   = '0;
    p_i_data = '0; p_i_eof = '0; p_i_vld = '0; p_o_rdy = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_full_boundary();
    test_wrap();
    test_back_to_back();
    test_pkt_mode();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
